// File: rtl/lab4_hilo_multiplier.sv
// HI/LO multiply unit for the lab4 MIPS datapath.
// mult/multu use an iterative shift-add loop that produces one product bit per cycle.
// The 64-bit product lands in HI/LO, and mfhi/mflo read it back combinationally.
module lab4_hilo_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       op,
  input  logic             enhilo,
  input  logic             hilo_sel,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam logic [3:0] OpMult    = 4'b0110;
  localparam logic [3:0] OpMultu   = 4'b0111;
  localparam logic [5:0] LastCount = 6'(WIDTH - 1);

  // StDone holds busy high for the cycle in which done pulses, so a back-to-back start is
  // stalled once.
  typedef enum logic [1:0] {StIdle, StMul, StFix, StDone} state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [5:0]           count_q, count_d;
  logic                 signed_mode_q, signed_mode_d;
  logic                 sign_diff_q, sign_diff_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 is_mult_op;
  logic                 start;
  logic [WIDTH-1:0]     rs_mag;
  logic [WIDTH-1:0]     rt_mag;
  logic [WIDTH:0]       add_sum;
  logic [2*WIDTH-1:0]   acc_shift;
  logic [2*WIDTH-1:0]   fix_result;

  // Decode the start condition and form the operand magnitudes and the shift-add step.
  always_comb begin
    is_mult_op = (op == OpMult) || (op == OpMultu);
    start      = enhilo && is_mult_op && (state_q == StIdle);
    // The magnitude of the most negative value wraps to itself and reads as unsigned.
    rs_mag     = ((op == OpMult) && rs_data[WIDTH-1]) ? -rs_data : rs_data;
    rt_mag     = ((op == OpMult) && rt_data[WIDTH-1]) ? -rt_data : rt_data;
    add_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    if (mplier_q[0]) begin
      add_sum = add_sum + {1'b0, mcand_q};
    end
    // The carry bit enters the top of the accumulator as it shifts right.
    acc_shift  = {add_sum, acc_q[WIDTH-1:1]};
    fix_result = (signed_mode_q && sign_diff_q) ? -acc_q : acc_q;
  end

  // State register plus datapath registers; reset discards any multiply in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      acc_q         <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      count_q       <= '0;
      signed_mode_q <= 1'b0;
      sign_diff_q   <= 1'b0;
      hi_q          <= '0;
      lo_q          <= '0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      mcand_q       <= mcand_d;
      mplier_q      <= mplier_d;
      count_q       <= count_d;
      signed_mode_q <= signed_mode_d;
      sign_diff_q   <= sign_diff_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
    end
  end

  // Next-state logic: IDLE -> MUL for WIDTH cycles -> FIX -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StMul;
      StMul:  if (count_q == LastCount) state_d = StFix;
      StFix:  state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: latch operands, iterate, then commit the sign-fixed product.
  always_comb begin
    acc_d         = acc_q;
    mcand_d       = mcand_q;
    mplier_d      = mplier_q;
    count_d       = count_q;
    signed_mode_d = signed_mode_q;
    sign_diff_d   = sign_diff_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d         = '0;
          mcand_d       = rs_mag;
          mplier_d      = rt_mag;
          count_d       = '0;
          signed_mode_d = (op == OpMult);
          sign_diff_d   = rs_data[WIDTH-1] ^ rt_data[WIDTH-1];
        end
      end
      StMul: begin
        acc_d    = acc_shift;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 6'd1;
      end
      StFix: begin
        hi_d = fix_result[2*WIDTH-1:WIDTH];
        lo_d = fix_result[WIDTH-1:0];
      end
      default: ;
    endcase
  end

  // Outputs: status flags from state, plus the move-from read mux.
  always_comb begin
    busy  = (state_q != StIdle);
    done  = (state_q == StDone);
    stall = enhilo && busy;
    hi    = hi_q;
    lo    = lo_q;
    rdata = hilo_sel ? lo_q : hi_q;
  end

endmodule

// File: tb/tb_lab4_hilo_multiplier.sv
// Self-checking bench for lab4_hilo_multiplier.
// It runs a cycle-level behavioural model and compares against it at every negedge.
// Directed vectors also check literal, hand-computed results.
module tb_lab4_hilo_multiplier;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [3:0]  op = 4'b0000;
  logic        enhilo = 1'b0;
  logic        hilo_sel = 1'b0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic [31:0] hi, lo, rdata;
  logic        busy, done, stall;

  int checks = 0;
  int failures = 0;
  int pcyc = 0;
  int t0 = 0;

  lab4_hilo_multiplier #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .op       (op),
    .enhilo   (enhilo),
    .hilo_sel (hilo_sel),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .hi       (hi),
    .lo       (lo),
    .rdata    (rdata),
    .busy     (busy),
    .done     (done),
    .stall    (stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pcyc <= pcyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Full-width product from plain arithmetic; low 64 bits of a sign-extended product are exact.
  function automatic logic [63:0] product(input logic [3:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] x, y;
    if (o == 4'b0110) begin
      x = {{32{a[31]}}, a};
      y = {{32{b[31]}}, b};
    end else begin
      x = {32'h0, a};
      y = {32'h0, b};
    end
    return x * y;
  endfunction

  // Model: phase counts cycles since the accepting edge.
  // Results appear 34 cycles later, and the unit is free again one cycle after that.
  int          phase = 0;
  logic [63:0] pend = '0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= 0;
      mhi   <= '0;
      mlo   <= '0;
    end else if (phase == 0) begin
      if (enhilo && (op == 4'b0110 || op == 4'b0111)) begin
        phase <= 1;
        pend  <= product(op, rs_data, rt_data);
      end
    end else if (phase == 34) begin
      phase <= 0;
    end else begin
      phase <= phase + 1;
      if (phase == 33) {mhi, mlo} <= pend;
    end
  end

  always @(negedge clk) begin
    chk("cyc_hi", hi, mhi);
    chk("cyc_lo", lo, mlo);
    chk("cyc_rdata", rdata, hilo_sel ? mlo : mhi);
    chk("cyc_busy", busy, phase != 0);
    chk("cyc_done", done, phase == 34);
    chk("cyc_stall", stall, enhilo && (phase != 0));
  end

  task automatic step(input logic en, input logic [3:0] o, input logic s,
                      input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    enhilo = en;
    op = o;
    hilo_sel = s;
    rs_data = a;
    rt_data = b;
  endtask

  task automatic start_mul(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                           input string name);
    step(1'b1, o, 1'b0, a, b);
    t0 = pcyc;
    #1 chk({name, "_busy_pre"}, busy, 1'b0);
    step(1'b0, 4'b0000, 1'b0, 32'h0, 32'h0);
    #1 chk({name, "_busy_1cyc"}, busy, 1'b1);
  endtask

  task automatic wait_done(input string name, input logic [31:0] eh, input logic [31:0] el);
    bit seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_done_seen"}, seen, 1'b1);
    if (seen) begin
      chk({name, "_latency"}, pcyc - t0, 34);
      chk({name, "_hi"}, hi, eh);
      chk({name, "_lo"}, lo, el);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int dseen;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_rdata_hi", rdata, 32'h0);
    hilo_sel = 1'b1;
    #1 chk("rst_rdata_lo", rdata, 32'h0);
    hilo_sel = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    step(1'b0, 4'b0000, 1'b0, 32'h0, 32'h0);

    start_mul(4'b0111, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_ff");
    wait_done("multu_ff", 32'hFFFFFFFE, 32'h00000001);
    chk("model_ff", {mhi, mlo}, 64'hFFFFFFFE_00000001);

    start_mul(4'b0110, 32'hFFFFFFFD, 32'h00000005, "mult_m3x5");
    wait_done("mult_m3x5", 32'hFFFFFFFF, 32'hFFFFFFF1);
    step(1'b1, 4'b0000, 1'b1, 32'h0, 32'h0);
    #1 chk("mflo_rdata", rdata, 32'hFFFFFFF1);
    chk("mflo_stall", stall, 1'b0);
    step(1'b1, 4'b0000, 1'b0, 32'h0, 32'h0);
    #1 chk("mfhi_rdata", rdata, 32'hFFFFFFFF);

    start_mul(4'b0110, 32'h80000000, 32'h80000000, "mult_min");
    wait_done("mult_min", 32'h40000000, 32'h00000000);
    // Start presented in the done cycle must stall and be taken one edge later.
    #1;
    enhilo = 1'b1;
    op = 4'b0111;
    rs_data = 32'h80000000;
    rt_data = 32'h80000000;
    #1 chk("stall_in_done", stall, 1'b1);
    start_mul(4'b0111, 32'h80000000, 32'h80000000, "multu_min");
    wait_done("multu_min", 32'h40000000, 32'h00000000);

    // HI/LO qualifier missing, or a non-HI/LO op, must not start anything.
    step(1'b0, 4'b0110, 1'b0, 32'h9, 32'h9);
    step(1'b1, 4'b0010, 1'b0, 32'h9, 32'h9);
    #1 chk("other_op_busy", busy, 1'b0);
    step(1'b0, 4'b0000, 1'b0, 32'h0, 32'h0);

    start_mul(4'b0111, 32'd100, 32'd200, "multu_bg");
    step(1'b1, 4'b0000, 1'b0, 32'h0, 32'h0);
    #1 chk("stall_mfhi", stall, 1'b1);
    step(1'b1, 4'b0111, 1'b0, 32'd3, 32'd7);
    #1 chk("stall_multu", stall, 1'b1);
    step(1'b0, 4'b0000, 1'b0, 32'h0, 32'h0);
    wait_done("multu_bg", 32'h0, 32'd20000);
    start_mul(4'b0111, 32'd3, 32'd7, "multu_3x7");
    wait_done("multu_3x7", 32'h0, 32'd21);

    start_mul(4'b0111, 32'h12345678, 32'h2, "rst_mid");
    repeat (10) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_done", done, 1'b0);
    chk("rst_mid_hi", hi, 32'h0);
    chk("rst_mid_lo", lo, 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    dseen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dseen++;
    end
    chk("rst_mid_no_done", dseen, 0);
    start_mul(4'b0111, 32'd2, 32'd2, "after_rst");
    wait_done("after_rst", 32'h0, 32'd4);

    step(1'b0, 4'b0000, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
